// File: rtl/timing_gen.sv
// timing_gen: beat/phase sequencer driving W[3:1] and T1..T3 for the hardwired controller
module timing_gen #(
   parameter int TDIV = 1,
   parameter int CYCW = 8
) (
   input  logic            MF,
   input  logic            CLR,
   input  logic            QD,
   input  logic            SHORT,
   input  logic            LONG,
   input  logic            STOP,
   output logic [3:1]      W,
   output logic            T1,
   output logic            T2,
   output logic            T3,
   output logic            RUN,
   output logic [CYCW-1:0] CYC
);
   localparam int CW = TDIV > 1 ? $clog2(TDIV) : 1;

   typedef enum logic {S_HALT, S_RUN} state_t;

   state_t        st;
   logic [CW-1:0] cnt;
   logic          qs1, qs2, qs3, stop_pend;
   logic          start, last, cyc_end, halt;

   // start edge, end of phase, and the decisions taken at the end-of-beat sample point
   always_comb begin
      start   = qs2 & ~qs3;
      last    = cnt == CW'(TDIV - 1);
      cyc_end = (W[1] & SHORT) | (W[2] & ~LONG) | W[3];
      halt    = stop_pend | STOP;
   end

   // sequencer: every output comes straight from a flop so T3 cannot glitch
   always_ff @(posedge MF or negedge CLR) begin
      if (!CLR) begin
         st        <= S_HALT;
         W         <= 3'b001;
         T1        <= 1'b0;
         T2        <= 1'b0;
         T3        <= 1'b0;
         RUN       <= 1'b0;
         CYC       <= '0;
         cnt       <= '0;
         stop_pend <= 1'b0;
         qs1       <= 1'b1;
         qs2       <= 1'b1;
         qs3       <= 1'b1;
      end else begin
         qs1 <= QD;
         qs2 <= qs1;
         qs3 <= qs2;
         if (st == S_HALT) begin
            if (start) begin
               st  <= S_RUN;
               RUN <= 1'b1;
               T1  <= 1'b1;
               cnt <= '0;
            end
         end else begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
               if (T1) begin
                  T1 <= 1'b0;
                  T2 <= 1'b1;
               end else if (T2) begin
                  T2 <= 1'b0;
                  T3 <= 1'b1;
               end else if (T3) begin
                  T3 <= 1'b0;
                  if (!cyc_end) begin
                     W         <= {W[2:1], 1'b0};
                     T1        <= 1'b1;
                     stop_pend <= halt;
                  end else begin
                     CYC       <= CYC + 1'b1;
                     W         <= 3'b001;
                     stop_pend <= 1'b0;
                     if (halt) begin
                        st  <= S_HALT;
                        RUN <= 1'b0;
                     end else begin
                        T1 <= 1'b1;
                     end
                  end
               end
            end
         end
      end
   end
endmodule
